fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_if_id_reg.sv | 42 ++++
 rtl/fetch_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage: vectors, JumpReq encodings and IF/ID control ops.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VECTOR_DEF   = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0008;
  localparam int          KERNEL_BIT       = 31;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_J    = 2'b01,
    JUMP_JR   = 2'b10,
    JUMP_RSVD = 2'b11
  } jump_req_e;

  typedef enum logic [1:0] {
    IFID_LOAD   = 2'b00,
    IFID_HOLD   = 2'b01,
    IFID_BUBBLE = 2'b10
  } ifid_op_e;

  // Sequential fetch never touches the kernel bit; the low 31 bits wrap on their own.
  function automatic logic [31:0] seq_next(input logic [31:0] pc);
    return {pc[KERNEL_BIT], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold on stall, or insert a nop bubble.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  ifid_op_e    op,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  // id_valid is a qualifier only: decode treats valid=0 as a nop, there is no ready back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr    <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          id_instr    <= instr;
          id_pc_plus4 <= pc_plus4;
          id_valid    <= 1'b1;
        end
        IFID_BUBBLE: begin
          id_instr    <= 32'h0;
          id_pc_plus4 <= pc_plus4;
          id_valid    <= 1'b0;
        end
        default: begin
          id_instr    <= id_instr;
          id_pc_plus4 <= id_pc_plus4;
          id_valid    <= id_valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: next-PC selection with redirect priority, interrupt entry, EPC capture.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] IRQ_VECTOR   = IRQ_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        ExcReq,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [1:0]  JumpReq,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  input  logic        IRQ,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        IrqTaken,
  output logic [31:0] EPC
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        irq_take;
  ifid_op_e    ifid_op;

  assign pc_plus4 = seq_next(pc);
  assign Address  = pc;

  // Any redirect (including interrupt entry) squashes the word fetched this cycle, even under Stall.
  always_comb begin
    next_pc  = pc_plus4;
    irq_take = 1'b0;
    ifid_op  = IFID_LOAD;
    if (ExcReq) begin
      next_pc = EXC_VECTOR;
      ifid_op = IFID_BUBBLE;
    end else if (BranchTaken) begin
      next_pc = BranchTarget;
      ifid_op = IFID_BUBBLE;
    end else if (JumpReq == JUMP_JR) begin
      next_pc = JrTarget;
      ifid_op = IFID_BUBBLE;
    end else if (JumpReq == JUMP_J) begin
      next_pc = {pc[KERNEL_BIT], JumpTarget[30:0]};
      ifid_op = IFID_BUBBLE;
    end else if (IRQ && !pc[KERNEL_BIT] && !Stall) begin
      next_pc  = IRQ_VECTOR;
      irq_take = 1'b1;
      ifid_op  = IFID_BUBBLE;
    end else if (Stall) begin
      next_pc = pc;
      ifid_op = IFID_HOLD;
    end
  end

  // EPC: exceptions return past the faulting word; interrupts re-fetch the dropped one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_VECTOR;
      EPC      <= 32'h0;
      IrqTaken <= 1'b0;
    end else begin
      pc       <= next_pc;
      IrqTaken <= irq_take;
      if (ExcReq)        EPC <= IF_ID_PCPlus4;
      else if (irq_take) EPC <= pc;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (reset),
    .op          (ifid_op),
    .instr       (Instruction),
    .pc_plus4    (pc_plus4),
    .id_instr    (IF_ID_Instruction),
    .id_pc_plus4 (IF_ID_PCPlus4),
    .id_valid    (IF_ID_Valid)
  );

endmodule
